// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake, registered outputs and an
// iterative shift-add unsigned multiplier (one partial product per cycle).
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MULU = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               zero_q, zero_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    // Single-cycle datapath, evaluated directly on the request inputs.
    logic [WIDTH-1:0] a_eff, b_eff;
    logic             b_inv;
    logic [WIDTH:0]   sum_w;
    logic             add_v;
    logic             less;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_legal;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        b_inv     = ALU_control[2];
        a_eff     = ALU_control[3] ? ~src1 : src1;
        b_eff     = b_inv ? ~src2 : src2;
        sum_w     = {1'b0, a_eff} + {1'b0, b_eff} + {{WIDTH{1'b0}}, b_inv};
        add_v     = (a_eff[WIDTH-1] == b_eff[WIDTH-1]) && (sum_w[WIDTH-1] != a_eff[WIDTH-1]);
        less      = sum_w[WIDTH-1] ^ add_v;
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_legal = 1'b1;
        case (ALU_control)
            OP_AND, OP_NOR: alu_res = a_eff & b_eff;   // NOR is ~a & ~b
            OP_OR:          alu_res = a_eff | b_eff;
            OP_ADD, OP_SUB: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = add_v;
            end
            OP_SLT:         alu_res = {{(WIDTH-1){1'b0}}, less};
            default:        alu_legal = 1'b0;
        endcase
    end

    // One shift-add step: conditional add into the upper half, then shift
    // {carry, accumulator} right so the carry is never lost.
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        upper_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
        acc_step  = {upper_sum, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (ALU_control == OP_MULU) begin
                        mcand_d  = src1;
                        mplier_d = src2;
                        acc_d    = '0;
                        cnt_d    = CW'(WIDTH);
                        state_d  = S_BUSY;
                    end else begin
                        // Undefined opcodes report every flag, including zero, as 0.
                        res_d   = alu_res;
                        hi_d    = '0;
                        zero_d  = alu_legal && (alu_res == '0);
                        cout_d  = alu_c;
                        ovf_d   = alu_v;
                        state_d = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                acc_d    = acc_step;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    res_d   = acc_step[WIDTH-1:0];
                    hi_d    = acc_step[2*WIDTH-1:WIDTH];
                    zero_d  = ~|acc_step;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = res_q;
    assign result_hi = hi_q;
    assign zero      = zero_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: behavioural model plus per-cycle monitor,
// directed corner cases, random traffic, reset mid-multiply and a WIDTH=8 instance.
module tb_alu_mc;

    localparam int W  = 32;
    localparam int W8 = 8;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MULU = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] src1, src2, result, result_hi;
    logic [3:0]   ALU_control;
    logic         zero, cout, overflow;

    logic          in_valid8, in_ready8, out_valid8, out_ready8;
    logic [W8-1:0] src1_8, src2_8, result8, result_hi8;
    logic [3:0]    ctl8;
    logic          zero8, cout8, overflow8;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .ALU_control(ALU_control),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi),
        .zero(zero), .cout(cout), .overflow(overflow)
    );

    alu_mc #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .src1(src1_8), .src2(src2_8), .ALU_control(ctl8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .result_hi(result_hi8),
        .zero(zero8), .cout(cout8), .overflow(overflow8)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         c;
        logic         v;
    } exp_t;

    typedef struct {
        exp_t e;
        int   cyc;
        int   lat;
    } txn_t;

    txn_t q[$];
    exp_t last_exp;
    int   cyc = 0;
    bit   rst_seen = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL timeout_%s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Reference semantics written from the opcode rules with plain arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t           e;
        longint         sa, sb, s;
        logic [2*W-1:0] p;
        longint         smax, smin;
        bit             legal;
        e     = '0;
        legal = 1'b1;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        smax  = (longint'(1) <<< (W - 1)) - 1;
        smin  = -(longint'(1) <<< (W - 1));
        case (op)
            OP_AND: e.res = a & b;
            OP_OR:  e.res = a | b;
            OP_NOR: e.res = ~(a | b);
            OP_ADD: begin
                {e.c, e.res} = {1'b0, a} + {1'b0, b};
                s   = sa + sb;
                e.v = (s > smax) || (s < smin);
            end
            OP_SUB: begin
                e.res = a - b;
                e.c   = (a >= b);
                s     = sa - sb;
                e.v   = (s > smax) || (s < smin);
            end
            OP_SLT: e.res = (sa < sb) ? W'(1) : W'(0);
            OP_MULU: begin
                p     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.hi  = p[2*W-1:W];
                e.res = p[W-1:0];
            end
            default: legal = 1'b0;
        endcase
        if (legal) e.z = (e.res == '0) && (e.hi == '0);
        return e;
    endfunction

    // Per-cycle monitor: handshake timing, latency and held output values.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            last_exp = '0;
            rst_seen = 1'b1;
        end else begin
            if (rst_seen) begin
                check("reset_in_ready", in_ready, 1);
                check("reset_out_valid", out_valid, 0);
                check("reset_outputs", {result, result_hi, zero, cout, overflow} == '0, 1);
                rst_seen = 1'b0;
            end
            check("in_ready", in_ready, q.size() == 0);
            check("ready_valid_excl", in_ready && out_valid, 0);
            if (q.size() == 0) check("out_valid", out_valid, 0);
            else check("out_valid", out_valid, (cyc - q[0].cyc) >= q[0].lat);
            if (out_valid && q.size() > 0) last_exp = q[0].e;
            check("result", result, last_exp.res);
            check("result_hi", result_hi, last_exp.hi);
            check("zero", zero, last_exp.z);
            check("cout", cout, last_exp.c);
            check("overflow", overflow, last_exp.v);
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready)
                q.push_back('{e: model(ALU_control, src1, src2), cyc: cyc,
                              lat: (ALU_control == OP_MULU) ? W + 1 : 1});
        end
    end

    task automatic wait_accept();
        int guard = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            guard++;
            if (guard > 100) begin
                timeout("accept");
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        src1     = $urandom;
        src2     = $urandom;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
        int guard = 0;
        @(posedge clk); #1;
        in_valid    = 1'b1;
        ALU_control = op;
        src1        = a;
        src2        = b;
        wait_accept();
        while (!out_valid && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!out_valid) timeout("out_valid");
        repeat (stall) begin
            @(posedge clk); #1;
            in_valid    = 1'($urandom_range(0, 1));
            src1        = $urandom;
            src2        = $urandom;
            ALU_control = 4'($urandom_range(0, 15));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t       m;
        logic [3:0] ops [7];
        logic [3:0] op;
        int         lat;
        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MULU};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        src1 = '0; src2 = '0; ALU_control = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; src1_8 = '0; src2_8 = '0; ctl8 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Literal pins on the model itself.
        m = model(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        check("pin_add_res", m.res, 32'h8000_0000);
        check("pin_add_flags", {m.z, m.c, m.v}, 3'b001);
        m = model(OP_SUB, 32'd5, 32'd5);
        check("pin_sub_eq", {m.res, m.z, m.c, m.v}, {32'h0, 3'b110});
        m = model(OP_SUB, 32'd0, 32'd1);
        check("pin_sub_neg", {m.res, m.z, m.c, m.v}, {32'hFFFF_FFFF, 3'b000});
        m = model(OP_SLT, 32'h8000_0000, 32'd1);
        check("pin_slt_a", m.res, 1);
        m = model(OP_SLT, 32'd1, 32'h8000_0000);
        check("pin_slt_b", m.res, 0);
        m = model(OP_SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        check("pin_slt_c", m.res, 0);
        m = model(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("pin_mulu", {m.hi, m.res}, 64'hFFFF_FFFE_0000_0001);
        m = model(4'b0100, 32'd0, 32'd0);
        check("pin_illegal", {m.res, m.z, m.c, m.v}, 35'h0);

        // Directed corner cases through the DUT.
        do_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        check("dir_add", {result, overflow, cout, zero}, {32'h8000_0000, 3'b100});
        do_op(OP_SUB, 32'd5, 32'd5, 0);
        do_op(OP_SUB, 32'd0, 32'd1, 1);
        check("dir_sub", {result, cout, overflow}, {32'hFFFF_FFFF, 2'b00});
        do_op(OP_SLT, 32'h8000_0000, 32'd1, 0);
        do_op(OP_SLT, 32'd1, 32'h8000_0000, 0);
        do_op(OP_SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("dir_mulu", {result_hi, result}, 64'hFFFF_FFFE_0000_0001);
        do_op(OP_NOR, 32'hF0F0_0000, 32'h0000_0F0F, 0);
        do_op(4'b1010, 32'd3, 32'd3, 0);
        // Backpressure: five stalled DONE cycles with garbage on the inputs.
        do_op(OP_ADD, 32'd10, 32'd20, 5);
        do_op(OP_MULU, 32'h0001_0000, 32'h0001_0000, 5);

        // Random traffic.
        for (int i = 0; i < 80; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 6)];
            do_op(op, rand_val(), rand_val(), $urandom_range(0, 3));
        end

        // Reset in the tenth BUSY cycle of a multiply.
        @(posedge clk); #1;
        in_valid = 1'b1; ALU_control = OP_MULU; src1 = $urandom; src2 = $urandom;
        wait_accept();
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        do_op(OP_ADD, 32'd2, 32'd3, 0);
        check("dir_add_after_reset", result, 5);

        // WIDTH=8 multiply latency and product.
        @(posedge clk); #1;
        in_valid8 = 1'b1; src1_8 = 8'hFF; src2_8 = 8'hFF; ctl8 = OP_MULU;
        @(negedge clk);
        check("w8_in_ready", in_ready8, 1);
        @(posedge clk); #1;
        in_valid8 = 1'b0; src1_8 = 8'h00; src2_8 = 8'h00;
        lat = 1;
        while (!out_valid8 && lat < 50) begin
            check("w8_busy_in_ready", in_ready8, 0);
            @(posedge clk); #1;
            lat++;
        end
        check("w8_latency", lat, 9);
        check("w8_product", {result_hi8, result8, zero8, cout8, overflow8}, {8'hFE, 8'h01, 3'b000});
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        check("w8_idle_after_consume", {in_ready8, out_valid8}, 2'b10);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU with a valid/ready handshake and registered outputs. It is the successor to the 32-bit combinational ripple ALU and keeps that block's ALU_control encoding and flag semantics. It is generalised to WIDTH bits and adds an iterative unsigned multiply. It sits between the register-file read stage and writeback, and the pipeline stalls on its handshake.

## Interface
- WIDTH, 32, operand/result width; legal range ≥ 2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request; high only in IDLE.
- src1  in  WIDTH  operand A, captured on accept.
- src2  in  WIDTH  operand B, captured on accept.
- ALU_control  in  4  opcode, captured on accept.
- out_valid  out  1  result/flags valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  result, or low half of product.
- result_hi  out  WIDTH  high half of product; 0 for non-multiply ops.
- zero  out  1  set when result (and result_hi) are all zero.
- cout  out  1  carry out of the MSB; ADD/SUB only.
- overflow  out  1  signed overflow; ADD/SUB only.

## Operation
- Opcodes, as {A_invert, B_invert, op[1:0]}:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (src1 + ~src2 + 1)
  - 0111 SLT
  - 1100 NOR
  - 0011 MULU
  - All other codes: result 0, all flags 0, completes like a single-cycle op.
- SLT: result = {0…0, less}, where less = sign(src1−src2) XOR overflow(src1−src2). This is a signed compare. cout and overflow outputs are 0.
- ADD/SUB:
  - cout is the carry out of bit WIDTH−1. For SUB, cout=1 means no borrow.
  - overflow = carry into MSB XOR carry out of MSB.
- AND/OR/NOR/SLT/MULU: cout=0, overflow=0.
- MULU: unsigned shift-add, one partial product per cycle. Result is the 2·WIDTH-bit product: result_hi is the upper half, result the lower half.
- zero = ~|{result_hi, result}.
- Operands and opcode are captured into internal registers on accept. Input changes after accept have no effect.
- FSM states:
  - IDLE: in_ready=1. On in_valid:
    - single-cycle op: compute and register outputs, go to DONE.
    - MULU: load multiplicand, multiplier and a zeroed accumulator, set counter=WIDTH, go to BUSY.
  - BUSY: each cycle:
    - if multiplier[0], add multiplicand to the upper half of the accumulator, keeping the carry;
    - shift {carry, accumulator} right by 1;
    - shift the multiplier right by 1;
    - decrement counter.
    When counter reaches 0, register the product and flags and go to DONE.
  - DONE: out_valid=1; outputs are held stable. On out_ready, go to IDLE.
- in_valid is ignored outside IDLE; the request is not lost, because in_ready=0 tells the producer to hold it.
- out_ready is ignored outside DONE.
- Counter width is $clog2(WIDTH)+1.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, and result, result_hi, zero, cout, overflow all 0.
- Reset mid-operation (BUSY or DONE): the next cycle is IDLE with reset values. The partial result is discarded and no out_valid pulse occurs.
- Single-cycle op accepted at edge k: out_valid is high from edge k+1.
- MULU accepted at edge k: out_valid is high from edge k+WIDTH+1, i.e. WIDTH cycles in BUSY.
- Result consumed (out_valid & out_ready) at edge m: in_ready is high after edge m; the next accept can occur at edge m+1.
- Throughput: at most one op per 2 cycles (single-cycle ops) or per WIDTH+2 cycles (MULU).
- in_ready and out_valid are never high in the same cycle.
- Outputs change only on the DONE-entry edge or on reset.

## Test plan
- ADD, WIDTH=32: 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow=1, cout=0, zero=0. out_valid asserts 1 cycle after accept.
- SUB: 5 − 5 -> result 0, zero=1, cout=1, overflow=0. SUB 0 − 1 -> 0xFFFFFFFF, cout=0, overflow=0.
- SLT:
  - src1=0x80000000, src2=1 -> result 1.
  - src1=1, src2=0x80000000 -> result 0.
  - src1=0x7FFFFFFF, src2=0xFFFFFFFF -> result 0 (overflow-corrected).
- MULU 0xFFFFFFFF × 0xFFFFFFFF -> result 0x00000001, result_hi 0xFFFFFFFE, zero=0. out_valid exactly 33 cycles after accept; in_ready=0 throughout. Repeat with WIDTH=8: 0xFF × 0xFF -> result_hi 0xFE, result 0x01, latency 9 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, toggling src1/src2/in_valid -> outputs unchanged and no accept. Raise out_ready -> in_ready=1 on the next cycle.
- Reset during BUSY at cycle 10 of a MULU -> next cycle: in_ready=1, out_valid=0, all outputs 0. A subsequent ADD 2+3 -> result 5 after 1 cycle.
